array_max_scanner: RTL and testbench
====================================

// Module: array_max_scanner
// PURPOSE
//  Memory-side initiator for the single-port 4096x16 data memory: scans COUNT words starting at
//  BASE, finds the signed maximum and its element index, writes both back to the result slots
//  (MAX_ADDR / IDX_ADDR) and pulses done. Drives the memory's address/Memread/Memwrite/write_data
//  and consumes its combinational read_data; sits beside the multi-cycle datapath as a bus master.
// PARAMETERS
//  ADDR_W    12       memory address width (word addressed)
//  DATA_W    16       memory word width; elements are two's-complement signed
//  MAX_ADDR  12'd200  result slot for the maximum value
//  IDX_ADDR  12'd204  result slot for the maximum's index (zero-extended to DATA_W)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous reset, active-low
//  start       in   1       1-cycle request; sampled only in IDLE
//  base        in   ADDR_W  first element address, latched on accepted start
//  count       in   ADDR_W  number of elements, latched on accepted start
//  address     out  ADDR_W  memory address
//  Memread     out  1       memory read enable
//  Memwrite    out  1       memory write enable (memory writes on posedge)
//  write_data  out  DATA_W  memory write data
//  read_data   in   DATA_W  memory read data, valid same cycle as address/Memread
//  busy        out  1       high from the cycle after accepted start until done
//  done        out  1       1-cycle pulse at completion
//  max         out  DATA_W  registered result value, held until next accepted start
//  max_index   out  DATA_W  registered result index, held until next accepted start
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE; address=0, Memread=0, Memwrite=0, write_data=0, busy=0,
//   done=0, max=0, max_index=0, internal counter i=0.
//  FSM: IDLE -> SCAN -> WR_MAX -> WR_IDX -> FIN -> IDLE.
//   IDLE:   start=1 latches base/count, i=0; count!=0 -> SCAN, count==0 -> FIN (no reads/writes,
//           max/max_index cleared to 0).
//   SCAN:   one element per cycle: address=base+i (mod 2^ADDR_W, wraps 4095->0), Memread=1.
//           At posedge: i==0 or $signed(read_data) > $signed(max) -> max<=read_data, max_index<=i.
//           Strict '>' : ties keep the first (lowest) index. i==count-1 -> WR_MAX, else i<=i+1.
//   WR_MAX: address=MAX_ADDR, write_data=max, Memwrite=1, Memread=0.
//   WR_IDX: address=IDX_ADDR, write_data={0,max_index}, Memwrite=1, Memread=0.
//   FIN:    done=1 for exactly this cycle, busy=0 next cycle; -> IDLE.
//  Outputs Memread/Memwrite/address/write_data are decoded from state (Moore); never both enables
//   high; both low in IDLE and FIN; address=0 in IDLE/FIN.
//  Latency: accepted start to done = count + 3 cycles (count>0); 1 cycle for count==0.
//  start while busy (any non-IDLE state) ignored, no queueing; start in the FIN cycle ignored.
//  Scan range overlapping MAX_ADDR/IDX_ADDR is legal: reads see pre-scan contents, results
//   overwrite afterwards. count up to 4095; range wraps modulo 2^ADDR_W.
//  Reset asserted mid-scan: immediate return to reset values; a half-finished write is not
//   retried; memory contents already written stay.
// STRUCTURE
//  Shared package: FSM state encoding (IDLE/SCAN/WR_MAX/WR_IDX/FIN), MAX_ADDR/IDX_ADDR defaults,
//   ADDR_W/DATA_W constants shared with the memory and datapath.
//  One sub-module natural: max_compare_reg (signed compare + max/max_index registers, first-load
//   and hold controls); FSM, counter and bus muxing stay in the top.
// TESTING
//  1. mem[0..9]={3,-1,7,2,7,0,-5,6,1,4}, base=0,count=10 -> done at start+13; mem[200]=7,
//     mem[204]=2; max=7, max_index=2 (tie keeps first).
//  2. All negative mem[50..53]={-8,-3,-3,-9}, count=4 -> max=16'hFFFD, max_index=1; Memread high
//     exactly 4 cycles, Memwrite exactly 2 cycles (addr 200 then 204).
//  3. count=0 -> done 1 cycle after start, no Memread/Memwrite pulses, max=0, max_index=0,
//     mem[200]/mem[204] unchanged.
//  4. base=4094,count=3 with mem[4094]=1,mem[4095]=2,mem[0]=9 -> addresses 4094,4095,0;
//     max=9, max_index=2.
//  5. start pulsed again during SCAN and in FIN -> ignored; single done; results from first run.
//  6. rst low during SCAN i=3 -> all outputs 0 same cycle; new start after release runs clean
//     from i=0; single-element count=1 -> max=mem[base], max_index=0, latency 4.

Source files
------------

// File: rtl/array_max_scanner_pkg.sv
// array_max_scanner_pkg
//   Constants shared between the max scanner, the 4096x16 data memory and the
//   multi-cycle datapath, plus the scanner FSM state encoding.
package array_max_scanner_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 16;

    localparam logic [MEM_ADDR_W-1:0] DEF_MAX_ADDR = 12'd200;
    localparam logic [MEM_ADDR_W-1:0] DEF_IDX_ADDR = 12'd204;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_WR_MAX = 3'd2,
        ST_WR_IDX = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

endpackage

// File: rtl/array_max_scanner_cmp.sv
// max_compare_reg
//   Running signed maximum and its element index.
//   Ports:
//     clk, rst      clock, asynchronous active-low reset
//     clear         zero both registers (empty scan)
//     sample        a new element is presented this cycle
//     first         element is the first of the scan; loads unconditionally
//     data          element value (two's complement)
//     index         element index, zero-extended into max_index
//     max           current maximum
//     max_index     index of the current maximum
module max_compare_reg
    import array_max_scanner_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int IDX_W  = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample,
    input  logic              first,
    input  logic [DATA_W-1:0] data,
    input  logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] max,
    output logic [DATA_W-1:0] max_index
);

    // Strict greater-than: equal values keep the earliest index.
    logic take;
    assign take = sample && (first || ($signed(data) > $signed(max)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max       <= '0;
            max_index <= '0;
        end else if (clear) begin
            max       <= '0;
            max_index <= '0;
        end else if (take) begin
            max       <= data;
            max_index <= DATA_W'(index);
        end
    end

endmodule

// File: rtl/array_max_scanner.sv
// array_max_scanner
//   Bus master on the single-port data memory: reads count words from base,
//   finds the signed maximum and its index, writes both to the result slots
//   and pulses done.
//   Ports:
//     clk, rst      clock, asynchronous active-low reset
//     start         request, honoured only in IDLE
//     base, count   scan window, latched on accepted start
//     address, Memread, Memwrite, write_data, read_data   memory bus
//     busy          scan in progress (through the done cycle)
//     done          single-cycle completion pulse
//     max, max_index  results, held until the next accepted start
//
//   state     | meaning
//   ST_IDLE   | waiting for start, bus quiet
//   ST_SCAN   | reading element base+i, one per cycle
//   ST_WR_MAX | writing max to MAX_ADDR
//   ST_WR_IDX | writing max_index to IDX_ADDR
//   ST_FIN    | done pulse, back to IDLE
module array_max_scanner
    import array_max_scanner_pkg::*;
#(
    parameter int                ADDR_W   = MEM_ADDR_W,
    parameter int                DATA_W   = MEM_DATA_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = DEF_MAX_ADDR,
    parameter logic [ADDR_W-1:0] IDX_ADDR = DEF_IDX_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] address,
    output logic              Memread,
    output logic              Memwrite,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] max,
    output logic [DATA_W-1:0] max_index
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q, count_q, idx_q;
    logic              accept, last;

    assign accept = (state == ST_IDLE) && start;
    // count_q is nonzero whenever SCAN is entered, so count_q-1 never wraps there.
    assign last   = (idx_q == count_q - ADDR_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else if (accept) begin
            base_q  <= base;
            count_q <= count;
            idx_q   <= '0;
        end else if (state == ST_SCAN && !last) begin
            idx_q   <= idx_q + ADDR_W'(1);
        end
    end

    max_compare_reg #(
        .DATA_W (DATA_W),
        .IDX_W  (ADDR_W)
    ) u_cmp (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept && (count == '0)),
        .sample    (state == ST_SCAN),
        .first     (idx_q == '0),
        .data      (read_data),
        .index     (idx_q),
        .max       (max),
        .max_index (max_index)
    );

    always_comb begin
        state_nxt  = state;
        address    = '0;
        Memread    = 1'b0;
        Memwrite   = 1'b0;
        write_data = '0;
        busy       = (state != ST_IDLE);
        done       = (state == ST_FIN);
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = (count == '0) ? ST_FIN : ST_SCAN;
            end
            ST_SCAN: begin
                address = base_q + idx_q;
                Memread = 1'b1;
                if (last) state_nxt = ST_WR_MAX;
            end
            ST_WR_MAX: begin
                address    = MAX_ADDR;
                write_data = max;
                Memwrite   = 1'b1;
                state_nxt  = ST_WR_IDX;
            end
            ST_WR_IDX: begin
                address    = IDX_ADDR;
                write_data = max_index;
                Memwrite   = 1'b1;
                state_nxt  = ST_FIN;
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_array_max_scanner.sv
module tb_array_max_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base = '0;
    logic [11:0] count = '0;
    logic [11:0] address;
    logic        Memread, Memwrite;
    logic [15:0] write_data, read_data;
    logic        busy, done;
    logic [15:0] max, max_index;

    logic [15:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    assign read_data = mem[address];

    always #5 clk = ~clk;

    array_max_scanner dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base       (base),
        .count      (count),
        .address    (address),
        .Memread    (Memread),
        .Memwrite   (Memwrite),
        .write_data (write_data),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .max        (max),
        .max_index  (max_index)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: signed max over the pre-scan window, first occurrence wins.
    function automatic void ref_scan(input logic [11:0] b, input int c,
                                     output logic [15:0] mx, output logic [15:0] mi);
        int best;
        int bi;
        logic [15:0] v;
        best = 0;
        bi   = 0;
        for (int k = 0; k < c; k++) begin
            v = mem[(int'(b) + k) % 4096];
            if (k == 0 || int'($signed(v)) > best) begin
                best = int'($signed(v));
                bi   = k;
            end
        end
        mx = best[15:0];
        mi = bi[15:0];
    endfunction

    task automatic run(input logic [11:0] b, input logic [11:0] c, input bit poke);
        logic [15:0] emx, emi, old200, old204, wdat;
        logic [11:0] waddr;
        int  rd, wr, lat;
        bit  seen, wpend;
        rd = 0; wr = 0; lat = 0; seen = 0; waddr = '0; wdat = '0;
        ref_scan(b, int'(c), emx, emi);
        old200 = mem[200];
        old204 = mem[204];
        @(negedge clk);
        start = 1'b1; base = b; count = c;
        @(posedge clk); #1;
        start = 1'b0; base = 12'($urandom); count = 12'($urandom);
        for (int cyc = 1; cyc <= int'(c) + 10; cyc++) begin
            if (cyc == 1) check("busy_after_start", busy, 1);
            start = poke && (cyc == 2);
            check("excl_en", Memread & Memwrite, 0);
            wpend = 0;
            if (Memread) begin
                check("rd_addr", address, (int'(b) + rd) % 4096);
                rd++;
            end
            if (Memwrite) begin
                check("wr_addr", address, (wr == 0) ? 200 : 204);
                check("wr_data", write_data, (wr == 0) ? emx : emi);
                waddr = address; wdat = write_data; wpend = 1; wr++;
            end
            if (done) begin
                lat = cyc; seen = 1;
                if (poke) start = 1'b1;
            end
            @(posedge clk);
            if (wpend) mem[waddr] = wdat;
            #1;
            if (seen) break;
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("latency", lat, (c == 0) ? 1 : int'(c) + 3);
        check("rd_cycles", rd, int'(c));
        check("wr_cycles", wr, (c == 0) ? 0 : 2);
        check("max", max, emx);
        check("max_index", max_index, emi);
        check("mem200", mem[200], (c == 0) ? old200 : emx);
        check("mem204", mem[204], (c == 0) ? old204 : emi);
        check("busy_after_done", busy, 0);
        check("done_single", done, 0);
        if (poke) begin
            @(posedge clk); #1;
            check("no_restart_busy", busy, 0);
            check("no_restart_done", done, 0);
        end
    endtask

    int t1 [10] = '{3, -1, 7, 2, 7, 0, -5, 6, 1, 4};
    int t2 [4]  = '{-8, -3, -3, -9};

    initial begin
        logic [11:0] rb;
        logic [11:0] rc;
        for (int a = 0; a < 4096; a++) mem[a] = 16'($urandom);

        #2;
        check("rst_address", address, 0);
        check("rst_memread", Memread, 0);
        check("rst_memwrite", Memwrite, 0);
        check("rst_wdata", write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_max", max, 0);
        check("rst_idx", max_index, 0);
        @(negedge clk);
        rst = 1'b1;

        // Ties keep the first index
        for (int k = 0; k < 10; k++) mem[k] = 16'(t1[k]);
        run(12'd0, 12'd10, 0);
        check("t1_max", max, 16'd7);
        check("t1_idx", max_index, 16'd2);
        check("t1_mem200", mem[200], 16'd7);
        check("t1_mem204", mem[204], 16'd2);

        // All negative
        for (int k = 0; k < 4; k++) mem[50 + k] = 16'(t2[k]);
        run(12'd50, 12'd4, 0);
        check("t2_max", max, 16'hFFFD);
        check("t2_idx", max_index, 16'd1);

        // Empty scan clears results
        run(12'd7, 12'd0, 0);
        check("t3_max", max, 16'd0);
        check("t3_idx", max_index, 16'd0);

        // Address wrap
        mem[4094] = 16'd1; mem[4095] = 16'd2; mem[0] = 16'd9;
        run(12'd4094, 12'd3, 0);
        check("t4_max", max, 16'd9);
        check("t4_idx", max_index, 16'd2);

        // Start pulses while busy and during FIN are ignored
        run(12'd300, 12'd10, 1);

        // Reset mid-scan
        for (int k = 0; k < 8; k++) mem[100 + k] = 16'($urandom_range(0, 200));
        @(negedge clk);
        start = 1'b1; base = 12'd100; count = 12'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_addr", address, 103);
        check("pre_rst_rd", Memread, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_address", address, 0);
        check("mid_rst_memread", Memread, 0);
        check("mid_rst_memwrite", Memwrite, 0);
        check("mid_rst_wdata", write_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_max", max, 0);
        check("mid_rst_idx", max_index, 0);
        @(negedge clk);
        rst = 1'b1;
        mem[600] = 16'h8123;
        run(12'd600, 12'd1, 0);
        check("t6_max", max, 16'h8123);
        check("t6_idx", max_index, 16'd0);

        // Randomized windows, half of them with narrow values to force ties
        for (int r = 0; r < 24; r++) begin
            rb = 12'($urandom);
            rc = 12'($urandom_range(1, 40));
            if (r % 6 == 5) rc = 12'd0;
            for (int k = 0; k < int'(rc); k++) begin
                if (r % 2 == 0) mem[(int'(rb) + k) % 4096] = 16'(int'($urandom_range(0, 15)) - 8);
                else            mem[(int'(rb) + k) % 4096] = 16'($urandom);
            end
            run(rb, rc, (r % 4 == 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
